// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C register-transaction sequencer: core
// register map, CR/SR bit positions, response status codes, FSM states and
// the command-register value issued for each byte phase.
package i2c_seq_pkg;

  localparam logic [2:0] PRER_LO = 3'd0;
  localparam logic [2:0] PRER_HI = 3'd1;
  localparam logic [2:0] CTR     = 3'd2;
  localparam logic [2:0] TXR_RXR = 3'd3;
  localparam logic [2:0] CR_SR   = 3'd4;

  // CR bits
  localparam int STA  = 7;
  localparam int STO  = 6;
  localparam int RD   = 5;
  localparam int WR   = 4;
  localparam int ACK  = 3;
  localparam int IACK = 0;

  // SR bits
  localparam int RXACK = 7;
  localparam int BUSY  = 6;
  localparam int AL    = 5;
  localparam int TIP   = 1;
  localparam int IF    = 0;

  localparam logic [7:0] CTR_EN  = 8'h80;
  localparam logic [7:0] CR_STOP = 8'h40;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_NACK     = 2'b01,
    ST_ARB_LOST = 2'b10,
    ST_TIMEOUT  = 2'b11
  } rsp_status_e;

  typedef enum logic [3:0] {
    INIT, IDLE, PH_TXR, PH_CR, POLL, RD_RXR, STOP, STOP_POLL, RESP
  } seq_state_e;

  // Byte phases: 0 address+START, 1 register, 2 write data (write) or
  // repeated-START address (read), 3 read with NACK and STOP (read only).
  function automatic logic [7:0] phase_cr(input logic rd, input logic [1:0] ph);
    logic [7:0] c;
    c = '0;
    if (ph == 2'd3) begin
      c[RD]  = 1'b1;
      c[ACK] = 1'b1;
      c[STO] = 1'b1;
    end else begin
      c[WR] = 1'b1;
      if (ph == 2'd0 || (rd && ph == 2'd2)) c[STA] = 1'b1;
      if (!rd && ph == 2'd2) c[STO] = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/i2c_wb_access.sv
// Single-beat Wishbone master used by the sequencer FSM.
// Ports:
//   clk, wb_rst_i            clock, synchronous active-high reset
//   start_i, we_i, adr_i,    launch one access (sampled only when idle)
//   dat_i
//   busy_o                   a cycle is on the bus
//   done_o                   one-cycle pulse after the access ends
//   timeout_o                valid with done_o: no ack within ACK_LIMIT cycles
//   rdata_o                  data captured on the ack cycle of a read
//   wb_*                     Wishbone master signals
module i2c_wb_access #(
  parameter logic [7:0] ACK_LIMIT = 8'd16
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] dat_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o,
  output logic [7:0] rdata_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  logic       cyc_q, we_q, done_q, to_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q, rdata_q, cnt_q;

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (cyc_q) begin
        if (wb_ack_i) begin
          cyc_q  <= 1'b0;
          done_q <= 1'b1;
          to_q   <= 1'b0;
          if (!we_q) rdata_q <= wb_dat_i;
        end else if (cnt_q == ACK_LIMIT - 8'd1) begin
          // cyc has been high for ACK_LIMIT cycles without an ack
          cyc_q  <= 1'b0;
          done_q <= 1'b1;
          to_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end else if (start_i) begin
        cyc_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= dat_i;
        cnt_q <= '0;
      end
    end
  end

  assign busy_o    = cyc_q;
  assign done_o    = done_q;
  assign timeout_o = to_q;
  assign rdata_o   = rdata_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_stb_o  = cyc_q;
  assign wb_cyc_o  = cyc_q;

endmodule

// File: rtl/i2c_wb_sequencer.sv
// Runs a complete I2C register read or write through the i2c_master_top
// register file: one-time core init, START/address/register/data byte
// phases with SR polling, STOP on NACK or poll timeout, and a single
// held response.
// Ports:
//   clk, wb_rst_i                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_rd,       command handshake and fields
//   cmd_dev, cmd_reg, cmd_wdata
//   rsp_valid/rsp_ready, rsp_rdata,    response handshake, read byte, status
//   rsp_status
//   wb_adr_o, wb_dat_o, wb_dat_i,      Wishbone master to the core
//   wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i
module i2c_wb_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE   = 16'h0063,
  parameter logic [19:0] POLL_LIMIT = 20'd200000,
  parameter logic [7:0]  ACK_LIMIT  = 8'd16
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i
);

  seq_state_e  state_q, state_d;
  rsp_status_e status_q, status_d;
  logic [1:0]  init_idx_q, init_idx_d, phase_q, phase_d;
  logic        rd_q, rd_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [19:0] poll_cnt_q, poll_cnt_d, poll_next;

  logic       acc_start, acc_we, acc_busy, acc_done, acc_to;
  logic [2:0] acc_adr;
  logic [7:0] acc_dat, acc_rdata, txr_byte;
  logic       issue, last_phase, wr_type;

  i2c_wb_access #(.ACK_LIMIT(ACK_LIMIT)) u_acc (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .start_i  (acc_start),
    .we_i     (acc_we),
    .adr_i    (acc_adr),
    .dat_i    (acc_dat),
    .busy_o   (acc_busy),
    .done_o   (acc_done),
    .timeout_o(acc_to),
    .rdata_o  (acc_rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q    <= INIT;
      status_q   <= ST_OK;
      init_idx_q <= '0;
      phase_q    <= '0;
      rd_q       <= 1'b0;
      dev_q      <= '0;
      reg_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      poll_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      init_idx_q <= init_idx_d;
      phase_q    <= phase_d;
      rd_q       <= rd_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    init_idx_d = init_idx_q;
    phase_d    = phase_q;
    rd_d       = rd_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    poll_cnt_d = poll_cnt_q;
    acc_start  = 1'b0;
    acc_we     = 1'b1;
    acc_adr    = CR_SR;
    acc_dat    = '0;

    // A new access is launched only once the previous one has fully ended
    // and its done pulse has been consumed by a state change.
    issue      = !acc_busy && !acc_done;
    poll_next  = (poll_cnt_q == POLL_LIMIT) ? poll_cnt_q : poll_cnt_q + 20'd1;
    last_phase = rd_q ? (phase_q == 2'd3) : (phase_q == 2'd2);
    wr_type    = !(rd_q && phase_q == 2'd3);

    case (phase_q)
      2'd0:    txr_byte = {dev_q, 1'b0};
      2'd1:    txr_byte = reg_q;
      2'd2:    txr_byte = rd_q ? {dev_q, 1'b1} : wdata_q;
      default: txr_byte = '0;
    endcase

    case (state_q)
      INIT: begin
        acc_start = issue;
        acc_adr   = {1'b0, init_idx_q};
        acc_dat   = (init_idx_q == 2'd0) ? PRESCALE[7:0] :
                    (init_idx_q == 2'd1) ? PRESCALE[15:8] : CTR_EN;
        if (acc_done) begin
          if (init_idx_q == 2'd2) state_d = IDLE;
          else                    init_idx_d = init_idx_q + 2'd1;
        end
      end
      IDLE: begin
        if (cmd_valid) begin
          rd_d     = cmd_rd;
          dev_d    = cmd_dev;
          reg_d    = cmd_reg;
          wdata_d  = cmd_wdata;
          rdata_d  = '0;
          status_d = ST_OK;
          phase_d  = '0;
          state_d  = PH_TXR;
        end
      end
      PH_TXR: begin
        acc_start = issue;
        acc_adr   = TXR_RXR;
        acc_dat   = txr_byte;
        if (acc_done) begin
          if (acc_to) begin status_d = ST_TIMEOUT; state_d = RESP; end
          else        state_d = PH_CR;
        end
      end
      PH_CR: begin
        acc_start = issue;
        acc_dat   = phase_cr(rd_q, phase_q);
        if (acc_done) begin
          poll_cnt_d = '0;
          if (acc_to) begin status_d = ST_TIMEOUT; state_d = RESP; end
          else        state_d = POLL;
        end
      end
      POLL: begin
        acc_start = issue;
        acc_we    = 1'b0;
        if (acc_done) begin
          if (acc_to) begin
            status_d = ST_TIMEOUT;
            state_d  = RESP;
          end else if (acc_rdata[TIP]) begin
            poll_cnt_d = poll_next;
            if (poll_next == POLL_LIMIT) begin status_d = ST_TIMEOUT; state_d = STOP; end
          end else if (acc_rdata[AL]) begin
            // Bus is no longer ours; a STOP would be meaningless.
            status_d = ST_ARB_LOST;
            state_d  = RESP;
          end else if (wr_type && acc_rdata[RXACK]) begin
            status_d = ST_NACK;
            state_d  = STOP;
          end else if (last_phase) begin
            state_d = rd_q ? RD_RXR : RESP;
          end else begin
            phase_d = phase_q + 2'd1;
            // The final read phase carries no transmit byte.
            state_d = (rd_q && phase_q == 2'd2) ? PH_CR : PH_TXR;
          end
        end
      end
      RD_RXR: begin
        acc_start = issue;
        acc_we    = 1'b0;
        acc_adr   = TXR_RXR;
        if (acc_done) begin
          if (acc_to) status_d = ST_TIMEOUT;
          else        rdata_d  = acc_rdata;
          state_d = RESP;
        end
      end
      STOP: begin
        acc_start = issue;
        acc_dat   = CR_STOP;
        if (acc_done) begin
          poll_cnt_d = '0;
          if (acc_to) begin status_d = ST_TIMEOUT; state_d = RESP; end
          else        state_d = STOP_POLL;
        end
      end
      STOP_POLL: begin
        acc_start = issue;
        acc_we    = 1'b0;
        if (acc_done) begin
          if (acc_to) begin
            status_d = ST_TIMEOUT;
            state_d  = RESP;
          end else if (acc_rdata[TIP]) begin
            poll_cnt_d = poll_next;
            if (poll_next == POLL_LIMIT) begin status_d = ST_TIMEOUT; state_d = RESP; end
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_status = status_q;

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
module tb_i2c_wb_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cmd_valid, cmd_ready, cmd_rd, rsp_valid, rsp_ready;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_wdata, rsp_rdata, wb_dat_o, wb_dat_i;
  logic [1:0] rsp_status;
  logic [2:0] wb_adr_o;
  logic       wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

  i2c_wb_sequencer #(.PRESCALE(16'h0063), .POLL_LIMIT(20'd8), .ACK_LIMIT(8'd16)) dut (
    .clk(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural core/slave: logs every acked write as {adr,dat}.
  logic [10:0] wlog[$];
  logic [10:0] exp_q[$];
  bit          no_ack = 0;
  int          nack_idx = -1, al_idx = -1, stuck_idx = -1;
  logic [7:0]  rx_byte = 8'h00;
  int          cr_cnt = 0, tip_left = 0, sr_since_cr = 0, sr_at_stop = 0, dly = 0;
  bit          cur_rxack = 0, cur_al = 0, stuck_now = 0;
  logic        ack_q = 1'b0;
  logic [7:0]  rdat_q = 8'h00;

  assign wb_ack_i = ack_q;
  assign wb_dat_i = rdat_q;

  always @(posedge clk) begin
    ack_q <= 1'b0;
    if (cmd_valid && cmd_ready) cr_cnt <= 0;
    if (rst) begin
      dly <= 0; tip_left <= 0; stuck_now <= 0; cur_rxack <= 0; cur_al <= 0; sr_since_cr <= 0;
    end else if (wb_cyc_o && wb_stb_o && !ack_q && !no_ack) begin
      if (dly > 0) dly <= dly - 1;
      else begin
        ack_q <= 1'b1;
        dly   <= $urandom_range(0, 2);
        if (wb_we_o) begin
          wlog.push_back({wb_adr_o, wb_dat_o});
          if (wb_adr_o == 3'd4) begin
            sr_since_cr <= 0;
            if (wb_dat_o == 8'h40) begin
              sr_at_stop <= sr_since_cr;
              tip_left <= $urandom_range(0, 2);
              stuck_now <= 0; cur_rxack <= 0; cur_al <= 0;
            end else begin
              tip_left  <= $urandom_range(0, 3);
              stuck_now <= (cr_cnt == stuck_idx);
              cur_rxack <= (cr_cnt == nack_idx);
              cur_al    <= (cr_cnt == al_idx);
              cr_cnt    <= cr_cnt + 1;
            end
          end
        end else if (wb_adr_o == 3'd4) begin
          sr_since_cr <= sr_since_cr + 1;
          if (stuck_now || tip_left > 0) begin
            rdat_q <= 8'h42;
            if (tip_left > 0) tip_left <= tip_left - 1;
          end else begin
            rdat_q <= {cur_rxack, 1'b0, cur_al, 5'b00000};
          end
        end else if (wb_adr_o == 3'd3) begin
          rdat_q <= rx_byte;
        end else begin
          rdat_q <= 8'h00;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: expected write list, status and read byte for one command.
  function automatic void build_expect(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                                       input logic [7:0] wd, input logic [7:0] rx,
                                       output logic [1:0] st, output logic [7:0] rdv);
    logic [7:0] txr[4];
    logic [7:0] cr[4];
    int n;
    txr[0] = {dev, 1'b0}; txr[1] = rg; txr[2] = rd ? {dev, 1'b1} : wd; txr[3] = 8'h00;
    cr[0] = 8'h90; cr[1] = 8'h10; cr[2] = rd ? 8'h90 : 8'h50; cr[3] = 8'h68;
    n = rd ? 4 : 3;
    exp_q.delete();
    st = 2'b00; rdv = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (!(rd && i == 3)) exp_q.push_back({3'd3, txr[i]});
      exp_q.push_back({3'd4, cr[i]});
      if (i == stuck_idx) begin exp_q.push_back({3'd4, 8'h40}); st = 2'b11; return; end
      if (i == al_idx) begin st = 2'b10; return; end
      if (i == nack_idx && !(rd && i == 3)) begin exp_q.push_back({3'd4, 8'h40}); st = 2'b01; return; end
    end
    rdv = rd ? rx : 8'h00;
  endfunction

  task automatic check_zero(input string tag);
    check(tag, {cmd_ready, rsp_valid, rsp_rdata, rsp_status, wb_adr_o, wb_dat_o,
                wb_we_o, wb_stb_o, wb_cyc_o}, 32'd0);
  endtask

  task automatic check_init(input string tag, input int base);
    int k = 0;
    while (!cmd_ready && k < 400) begin @(negedge clk); k++; end
    check({tag, "/ready"}, cmd_ready, 1);
    check({tag, "/nwr"}, wlog.size() - base, 3);
    if (wlog.size() - base >= 3) begin
      check({tag, "/w0"}, wlog[base],     {3'd0, 8'h63});
      check({tag, "/w1"}, wlog[base + 1], {3'd1, 8'h00});
      check({tag, "/w2"}, wlog[base + 2], {3'd2, 8'h80});
    end
  endtask

  task automatic run_txn(input string tag, input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [7:0] rx, input int bp, input bit early);
    logic [1:0] st_e, hold_s;
    logic [7:0] rd_e, hold_d;
    int base, k;
    bit bad_busy, bad_hold;
    rx_byte = rx;
    build_expect(rd, dev, rg, wd, rx, st_e, rd_e);
    k = 0;
    while (!cmd_ready && k < 400) begin @(negedge clk); k++; end
    check({tag, "/ready"}, cmd_ready, 1);
    if (!cmd_ready) return;
    base = wlog.size();
    cmd_valid = 1; cmd_rd = rd; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; rsp_ready = early;
    @(negedge clk);
    cmd_valid = 0; cmd_rd = 1'($urandom); cmd_dev = 7'($urandom);
    cmd_reg = 8'($urandom); cmd_wdata = 8'($urandom);
    check({tag, "/ready_drop"}, cmd_ready, 0);
    bad_busy = 0; k = 0;
    while (!rsp_valid && k < 4000) begin
      if (cmd_ready) bad_busy = 1;
      @(negedge clk); k++;
    end
    check({tag, "/busy_ready"}, bad_busy, 0);
    check({tag, "/rsp_valid"}, rsp_valid, 1);
    if (!rsp_valid) return;
    hold_d = rsp_rdata; hold_s = rsp_status; bad_hold = 0;
    if (!early) begin
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        if (!rsp_valid || cmd_ready || rsp_rdata !== hold_d || rsp_status !== hold_s) bad_hold = 1;
      end
      check({tag, "/hold"}, bad_hold, 0);
      rsp_ready = 1;
    end
    @(negedge clk);
    rsp_ready = 0;
    check({tag, "/after"}, {rsp_valid, cmd_ready}, 2'b01);
    check({tag, "/status"}, hold_s, st_e);
    check({tag, "/rdata"}, hold_d, rd_e);
    check({tag, "/nwr"}, wlog.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < wlog.size(); i++)
      check($sformatf("%s/wr%0d", tag, i), wlog[base + i], exp_q[i]);
    if (stuck_idx >= 0) check({tag, "/sr_reads"}, sr_at_stop, 8);
  endtask

  initial begin
    int base, k, r, n;
    bit rd;
    rst = 1; cmd_valid = 0; cmd_rd = 0; cmd_dev = 0; cmd_reg = 0; cmd_wdata = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    base = wlog.size();
    rst = 0;
    check_init("init", base);

    run_txn("wr_basic", 0, 7'h50, 8'h10, 8'hA5, 8'h00, 3, 0);
    run_txn("rd_basic", 1, 7'h50, 8'h10, 8'h00, 8'h3C, 0, 1);
    nack_idx = 0;
    run_txn("nack_addr", 0, 7'h50, 8'h10, 8'hA5, 8'h00, 2, 0);
    nack_idx = -1; stuck_idx = 1;
    run_txn("stuck_tip", 1, 7'h2A, 8'h77, 8'h00, 8'h99, 1, 0);
    stuck_idx = -1;
    run_txn("bp20", 1, 7'h11, 8'h22, 8'h00, 8'hE7, 20, 0);

    // Core that never acknowledges.
    no_ack = 1;
    k = 0;
    while (!cmd_ready && k < 400) begin @(negedge clk); k++; end
    base = wlog.size();
    cmd_valid = 1; cmd_rd = 0; cmd_dev = 7'h33; cmd_reg = 8'h44; cmd_wdata = 8'h55;
    @(negedge clk);
    cmd_valid = 0;
    k = 0;
    while (!wb_cyc_o && k < 20) begin @(negedge clk); k++; end
    n = 0;
    while (wb_cyc_o && n < 60) begin @(negedge clk); n++; end
    check("noack/cyc_cycles", n, 16);
    k = 0;
    while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
    check("noack/status", {rsp_valid, rsp_status, rsp_rdata}, {1'b1, 2'b11, 8'h00});
    rsp_ready = 1; @(negedge clk); rsp_ready = 0;
    check("noack/nwr", wlog.size() - base, 0);
    no_ack = 0;

    for (int t = 0; t < 12; t++) begin
      rd = 1'($urandom);
      n  = rd ? 4 : 3;
      r  = $urandom_range(0, 5);
      nack_idx = -1; al_idx = -1; stuck_idx = -1;
      if (r == 3) nack_idx = $urandom_range(0, n - 1);
      if (r == 4) al_idx = $urandom_range(0, n - 1);
      if (r == 5) stuck_idx = $urandom_range(0, n - 1);
      run_txn($sformatf("rnd%0d", t), rd, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
    end
    nack_idx = -1; al_idx = -1;

    // Reset while polling a stuck phase.
    stuck_idx = 1;
    k = 0;
    while (!cmd_ready && k < 400) begin @(negedge clk); k++; end
    cmd_valid = 1; cmd_rd = 0; cmd_dev = 7'h50; cmd_reg = 8'h01; cmd_wdata = 8'h02;
    @(negedge clk);
    cmd_valid = 0;
    k = 0;
    while (!(cr_cnt == 2 && sr_since_cr >= 3) && k < 500) begin @(negedge clk); k++; end
    check("midpoll/reached", (cr_cnt == 2 && sr_since_cr >= 3), 1);
    rst = 1;
    @(negedge clk);
    check_zero("midpoll/reset");
    stuck_idx = -1;
    base = wlog.size();
    rst = 0;
    check_init("reinit", base);
    run_txn("post_reset", 0, 7'h0F, 8'hF0, 8'h5A, 8'h00, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
